// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port: one-entry buffer per
// producer (ALU, ID), fixed ALU priority with a starvation bound, same-register ordering.
module regfile_wb_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        alu_valid_i,
  input  logic [2:0]  alu_addr_i,
  input  logic [31:0] alu_data_i,
  output logic        alu_ready_o,
  input  logic        id_valid_i,
  input  logic [2:0]  id_addr_i,
  input  logic [31:0] id_data_i,
  output logic        id_ready_o,
  output logic        write_enable_o,
  output logic [2:0]  write_addr_o,
  output logic [31:0] write_value_alu_o,
  output logic [31:0] write_value_id_o,
  output logic        write_data_sel_o,
  output logic [7:0]  busy_mask_o
);

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} buf_state_e;

  buf_state_e  alu_st_q, alu_st_d, id_st_q, id_st_d;
  logic [2:0]  alu_addr_q, alu_addr_d, id_addr_q, id_addr_d;
  logic [31:0] alu_data_q, alu_data_d, id_data_q, id_data_d;
  logic        alu_older_q, alu_older_d;
  logic [2:0]  starve_q, starve_d;
  logic        we_q, we_d, sel_q, sel_d;
  logic [2:0]  waddr_q, waddr_d;
  logic [31:0] val_alu_q, val_alu_d, val_id_q, val_id_d;
  logic        grant_alu, grant_id, alu_keep, id_keep;

  // Same-register pairs follow acceptance order, even against the starvation bound.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    grant_alu = 1'b0;
    grant_id  = 1'b0;
    if (alu_st_q == FULL && id_st_q == FULL) begin
      if (alu_addr_q == id_addr_q) begin
        grant_alu = alu_older_q;
        grant_id  = !alu_older_q;
      end else if (starve_q == LIMIT) begin
        grant_id = 1'b1;
      end else begin
        grant_alu = 1'b1;
      end
    end else begin
      grant_alu = (alu_st_q == FULL);
      grant_id  = (id_st_q == FULL);
    end
  end

  assign alu_ready_o = !reset_i && (alu_st_q == EMPTY || grant_alu);
  assign id_ready_o  = !reset_i && (id_st_q == EMPTY || grant_id);

  always_comb begin
    alu_st_d   = alu_st_q;
    alu_addr_d = alu_addr_q;
    alu_data_d = alu_data_q;
    id_st_d    = id_st_q;
    id_addr_d  = id_addr_q;
    id_data_d  = id_data_q;
    if (grant_alu) alu_st_d = EMPTY;
    if (grant_id)  id_st_d  = EMPTY;
    if (alu_valid_i && alu_ready_o) begin
      alu_st_d   = FULL;
      alu_addr_d = alu_addr_i;
      alu_data_d = alu_data_i;
    end
    if (id_valid_i && id_ready_o) begin
      id_st_d   = FULL;
      id_addr_d = id_addr_i;
      id_data_d = id_data_i;
    end

    // A buffer that stays FULL is older than one refilled this edge; ties go to ID.
    alu_keep    = (alu_st_q == FULL) && !grant_alu;
    id_keep     = (id_st_q == FULL) && !grant_id;
    alu_older_d = (alu_keep && id_keep) ? alu_older_q : alu_keep;

    starve_d = starve_q;
    if (id_st_q == EMPTY || grant_id) starve_d = 3'd0;
    else if (grant_alu && starve_q != LIMIT) starve_d = starve_q + 3'd1;

    we_d      = grant_alu || grant_id;
    waddr_d   = waddr_q;
    sel_d     = sel_q;
    val_alu_d = val_alu_q;
    val_id_d  = val_id_q;
    if (grant_alu) begin
      waddr_d   = alu_addr_q;
      sel_d     = 1'b1;
      val_alu_d = alu_data_q;
      val_id_d  = 32'd0;
    end else if (grant_id) begin
      waddr_d   = id_addr_q;
      sel_d     = 1'b0;
      val_alu_d = 32'd0;
      val_id_d  = id_data_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      alu_st_q    <= EMPTY;
      alu_addr_q  <= '0;
      alu_data_q  <= '0;
      id_st_q     <= EMPTY;
      id_addr_q   <= '0;
      id_data_q   <= '0;
      alu_older_q <= 1'b0;
      starve_q    <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      sel_q       <= 1'b0;
      val_alu_q   <= '0;
      val_id_q    <= '0;
    end else begin
      alu_st_q    <= alu_st_d;
      alu_addr_q  <= alu_addr_d;
      alu_data_q  <= alu_data_d;
      id_st_q     <= id_st_d;
      id_addr_q   <= id_addr_d;
      id_data_q   <= id_data_d;
      alu_older_q <= alu_older_d;
      starve_q    <= starve_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      sel_q       <= sel_d;
      val_alu_q   <= val_alu_d;
      val_id_q    <= val_id_d;
    end
  end

  always_comb begin
    busy_mask_o = 8'h00;
    if (alu_st_q == FULL) busy_mask_o[alu_addr_q] = 1'b1;
    if (id_st_q == FULL)  busy_mask_o[id_addr_q]  = 1'b1;
    if (we_q)             busy_mask_o[waddr_q]    = 1'b1;
  end

  assign write_enable_o    = we_q;
  assign write_addr_o      = waddr_q;
  assign write_data_sel_o  = sel_q;
  assign write_value_alu_o = val_alu_q;
  assign write_value_id_o  = val_id_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic, all compared
// cycle by cycle against a transaction-level model using sequence numbers for age.
module tb_regfile_wb_arbiter;
  localparam int STARVE_LIMIT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, id_valid;
  logic [2:0]  alu_addr, id_addr;
  logic [31:0] alu_data, id_data;
  logic        alu_ready, id_ready;
  logic        write_enable, write_data_sel;
  logic [2:0]  write_addr;
  logic [31:0] write_value_alu, write_value_id;
  logic [7:0]  busy_mask;

  regfile_wb_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .alu_valid_i      (alu_valid),
    .alu_addr_i       (alu_addr),
    .alu_data_i       (alu_data),
    .alu_ready_o      (alu_ready),
    .id_valid_i       (id_valid),
    .id_addr_i        (id_addr),
    .id_data_i        (id_data),
    .id_ready_o       (id_ready),
    .write_enable_o   (write_enable),
    .write_addr_o     (write_addr),
    .write_value_alu_o(write_value_alu),
    .write_value_id_o (write_value_id),
    .write_data_sel_o (write_data_sel),
    .busy_mask_o      (busy_mask)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic        full;
    logic [2:0]  addr;
    logic [31:0] data;
    logic [31:0] seq;
  } req_t;

  req_t        m_alu, m_id;
  logic [31:0] seq_ctr;
  int          starve;
  logic        m_we, m_sel;
  logic [2:0]  m_addr;
  logic [31:0] m_va, m_vi;
  logic [31:0] rf_exp [8];
  logic [31:0] rf_dut [8];

  task automatic model_reset();
    m_alu  = '0;
    m_id   = '0;
    starve = 0;
    m_we   = 1'b0;
    m_sel  = 1'b0;
    m_addr = '0;
    m_va   = '0;
    m_vi   = '0;
  endtask

  task automatic drive(input logic av, input logic [2:0] aa, input logic [31:0] ad,
                       input logic iv, input logic [2:0] ia, input logic [31:0] idat);
    alu_valid = av; alu_addr = aa; alu_data = ad;
    id_valid  = iv; id_addr  = ia; id_data  = idat;
  endtask

  // Called at a falling edge with inputs applied; compares, advances the model, waits a cycle.
  task automatic step();
    logic       g_alu, g_id, r_alu, r_id;
    logic [7:0] busy;
    #1;
    g_alu = 1'b0;
    g_id  = 1'b0;
    if (m_alu.full && m_id.full) begin
      if (m_alu.addr == m_id.addr) begin
        if (m_alu.seq < m_id.seq) g_alu = 1'b1;
        else g_id = 1'b1;
      end else if (starve >= STARVE_LIMIT) g_id = 1'b1;
      else g_alu = 1'b1;
    end else begin
      g_alu = m_alu.full;
      g_id  = m_id.full;
    end
    r_alu = !reset && (!m_alu.full || g_alu);
    r_id  = !reset && (!m_id.full || g_id);
    busy = 8'h00;
    if (m_alu.full) busy[m_alu.addr] = 1'b1;
    if (m_id.full)  busy[m_id.addr]  = 1'b1;
    if (m_we)       busy[m_addr]     = 1'b1;

    check("write_enable", 32'(write_enable), 32'(m_we));
    check("write_addr", 32'(write_addr), 32'(m_addr));
    check("write_data_sel", 32'(write_data_sel), 32'(m_sel));
    check("write_value_alu", write_value_alu, m_va);
    check("write_value_id", write_value_id, m_vi);
    check("busy_mask", 32'(busy_mask), 32'(busy));
    check("alu_ready", 32'(alu_ready), 32'(r_alu));
    check("id_ready", 32'(id_ready), 32'(r_id));

    if (write_enable) rf_dut[write_addr] = write_data_sel ? write_value_alu : write_value_id;

    if (reset) begin
      model_reset();
    end else begin
      if (!m_id.full || g_id) starve = 0;
      else if (g_alu && starve < STARVE_LIMIT) starve++;
      m_we = g_alu || g_id;
      if (g_alu) begin
        m_addr = m_alu.addr; m_sel = 1'b1; m_va = m_alu.data; m_vi = '0;
        rf_exp[m_alu.addr] = m_alu.data;
        m_alu.full = 1'b0;
      end
      if (g_id) begin
        m_addr = m_id.addr; m_sel = 1'b0; m_va = '0; m_vi = m_id.data;
        rf_exp[m_id.addr] = m_id.data;
        m_id.full = 1'b0;
      end
      // ID is numbered first so a simultaneous pair counts ID as older.
      if (id_valid && r_id) begin
        m_id = {1'b1, id_addr, id_data, seq_ctr};
        seq_ctr++;
      end
      if (alu_valid && r_alu) begin
        m_alu = {1'b1, alu_addr, alu_data, seq_ctr};
        seq_ctr++;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    drive(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    seq_ctr = 0;
    for (int r = 0; r < 8; r++) begin
      rf_exp[r] = '0;
      rf_dut[r] = '0;
    end
    model_reset();
    reset = 1'b1;
    drive(1'b1, 3'd1, 32'h1, 1'b1, 3'd2, 32'h2);
    @(negedge clk);

    // Reset held with both valids high, then released.
    step();
    step();
    reset = 1'b0;
    idle(4);

    // Single ALU write.
    drive(1'b1, 3'd3, 32'hDEADBEEF, 1'b0, 3'd0, 32'd0);
    step();
    drive(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0);
    check("single busy c1", 32'(busy_mask), 32'h08);
    step();
    check("single we c2", 32'(write_enable), 32'd1);
    check("single addr c2", 32'(write_addr), 32'd3);
    check("single sel c2", 32'(write_data_sel), 32'd1);
    check("single val_alu c2", write_value_alu, 32'hDEADBEEF);
    check("single val_id c2", write_value_id, 32'd0);
    check("single busy c2", 32'(busy_mask), 32'h08);
    idle(3);

    // Simultaneous requests to different registers.
    drive(1'b1, 3'd1, 32'h11, 1'b1, 3'd2, 32'h22);
    step();
    drive(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0);
    check("simul busy c1", 32'(busy_mask), 32'h06);
    step();
    check("simul alu c2", {write_enable, write_data_sel, 27'd0, write_addr}, {2'b11, 27'd0, 3'd1});
    step();
    check("simul id c3", {write_enable, write_data_sel, 27'd0, write_addr}, {2'b10, 27'd0, 3'd2});
    check("simul id val c3", write_value_id, 32'h22);
    idle(3);

    // Starvation bound under continuous ALU traffic.
    drive(1'b1, 3'd4, 32'h400, 1'b1, 3'd5, 32'h5A5A);
    step();
    for (int c = 1; c <= 5; c++) begin
      if (c >= 2 && c <= 4)
        check("starve alu grant", {write_enable, write_data_sel, 27'd0, write_addr},
              {2'b11, 27'd0, 3'd4});
      if (c == 5) begin
        check("starve id grant", {write_enable, write_data_sel, 27'd0, write_addr},
              {2'b10, 27'd0, 3'd5});
        check("starve id val", write_value_id, 32'h5A5A);
      end
      drive(1'b1, 3'd4, 32'h400 + 32'(c), 1'b0, 3'd0, 32'd0);
      step();
    end
    idle(4);

    // Same-register ordering: ID r6 accepted before ALU r6.
    drive(1'b1, 3'd1, 32'h1, 1'b0, 3'd0, 32'd0);
    step();
    drive(1'b1, 3'd2, 32'h2, 1'b1, 3'd6, 32'hAAAA);
    step();
    drive(1'b1, 3'd6, 32'h5555, 1'b0, 3'd0, 32'd0);
    step();
    drive(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0);
    step();
    check("order id first", {write_enable, write_data_sel, 27'd0, write_addr}, {2'b10, 27'd0, 3'd6});
    check("order id val", write_value_id, 32'hAAAA);
    step();
    check("order alu second", {write_enable, write_data_sel, 27'd0, write_addr}, {2'b11, 27'd0, 3'd6});
    check("order alu val", write_value_alu, 32'h5555);
    idle(3);
    check("order r6 final", rf_dut[6], 32'h5555);

    // Reset with both buffers full.
    drive(1'b1, 3'd3, 32'h33, 1'b1, 3'd4, 32'h44);
    step();
    drive(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midreset we", 32'(write_enable), 32'd0);
    check("midreset busy", 32'(busy_mask), 32'd0);
    step();
    check("midreset we after", 32'(write_enable), 32'd0);
    idle(2);

    // Random traffic with address collisions and occasional resets.
    for (int c = 0; c < 800; c++) begin
      reset = ($urandom_range(0, 79) == 0);
      drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 3)), $urandom,
            $urandom_range(0, 2) != 0, 3'($urandom_range(0, 3)), $urandom);
      step();
    end
    reset = 1'b0;
    idle(6);

    for (int r = 0; r < 8; r++) check($sformatf("rf r%0d", r), rf_dut[r], rf_exp[r]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
